coin_session_arbiter: RTL

- Shares one coin_counter_wrapper core among N_PORTS customer kiosks.
- Grants the core to one kiosk per session in round-robin order, then routes that kiosk's purchase and coin channels to the core.
- Steers the core's dispense and change channels back to the granted kiosk.
- Tracks money in nickel units to decide when change is complete, then releases the grant.

---
 rtl/coin_pkg.sv | 58 +++++
 rtl/coin_session_arbiter_rr.sv | 36 +++
 rtl/coin_session_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/coin_pkg.sv
// Shared types and helpers for the coin session arbiter.
// Provides coin codes, session states, coin-to-nickel conversion,
// nickel-to-Q4.12 price conversion and a saturating nickel adder.
package coin_pkg;

    localparam int unsigned WIDTH      = 16;
    localparam int unsigned FRAC_BITS  = 12;
    localparam int unsigned COIN_WIDTH = 3;
    localparam int unsigned PRICE_W    = 9;
    localparam int unsigned NICKEL_W   = 10;
    localparam int unsigned COIN_N_W   = 5;
    localparam int unsigned SUM_W      = NICKEL_W + 1;
    localparam int unsigned PROD_W     = 24;
    localparam int unsigned FX_SCALE   = 13107;
    localparam int unsigned FX_ROUND   = 32;
    localparam int unsigned FX_SHIFT   = 6;

    typedef enum logic [COIN_WIDTH-1:0] {
        COIN_NONE    = 3'd0,
        COIN_NICKEL  = 3'd1,
        COIN_DIME    = 3'd2,
        COIN_QUARTER = 3'd3,
        COIN_HALF    = 3'd4,
        COIN_DOLLAR  = 3'd5
    } coin_code_t;

    typedef enum logic [2:0] {
        IDLE, PURCHASE, COIN, DISPENSE, CHANGE, RELEASE
    } session_state_t;

    // Coin value in nickels; unknown codes are worth nothing.
    function automatic logic [COIN_N_W-1:0] coin_nickels(input logic [COIN_WIDTH-1:0] code);
        case (code)
            COIN_NICKEL:  return 5'd1;
            COIN_DIME:    return 5'd2;
            COIN_QUARTER: return 5'd5;
            COIN_HALF:    return 5'd10;
            COIN_DOLLAR:  return 5'd20;
            default:      return 5'd0;
        endcase
    endfunction

    // Nickels to Q4.12: n * 0.05 * 4096 == n * 13107 / 64, rounded.
    function automatic logic [WIDTH-1:0] price_to_fixed(input logic [PRICE_W-1:0] price_n);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(price_n) * PROD_W'(FX_SCALE) + PROD_W'(FX_ROUND);
        return prod[FX_SHIFT +: WIDTH];
    endfunction

    // Nickel accumulator add, saturating at all ones.
    function automatic logic [NICKEL_W-1:0] nickel_add(input logic [NICKEL_W-1:0] a,
                                                       input logic [COIN_N_W-1:0] b);
        logic [SUM_W-1:0] s;
        s = {1'b0, a} + SUM_W'(b);
        return s[NICKEL_W] ? '1 : s[NICKEL_W-1:0];
    endfunction

endpackage

// File: rtl/coin_session_arbiter_rr.sv
// Round-robin arbiter: first set request at or above ptr, with wrap.
// Ports: req (request vector), ptr (search start), gnt (one-hot),
//        idx (granted index), any (some request present).
module rr_arbiter #(
    parameter int unsigned N_PORTS = 4,
    parameter int unsigned PORT_W  = 3
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [PORT_W-1:0]  ptr,
    output logic [N_PORTS-1:0] gnt,
    output logic [PORT_W-1:0]  idx,
    output logic               any
);

    localparam int unsigned N2 = 2 * N_PORTS;

    logic [N2-1:0] rot;
    int unsigned   pos;

    // Rotate a doubled request vector so the scan always starts at bit 0.
    always_comb begin
        rot = {req, req} >> ptr;
        pos = 0;
        any = 1'b0;
        for (int unsigned off = 0; off < N_PORTS; off++) begin
            if (!any && rot[off]) begin
                any = 1'b1;
                pos = 32'(ptr) + off;
            end
        end
        if (pos >= N_PORTS) pos = pos - N_PORTS;
        gnt = any ? (N_PORTS'(1) << pos) : '0;
        idx = PORT_W'(pos);
    end

endmodule

// File: rtl/coin_session_arbiter.sv
// Shares one coin core among N_PORTS kiosks, one session at a time.
// Ports: clock/reset; per-kiosk purchase, coin, dispense and change
// channels (k_*); core-side channels (c_*); grant (one-hot owner) and
// session_abort (one-cycle pulse when a session times out).
module coin_session_arbiter
    import coin_pkg::*;
#(
    parameter int unsigned N_PORTS = 4,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned PORT_W  = 3
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [N_PORTS*PRICE_W-1:0]      k_purchase_msg,
    input  logic [N_PORTS-1:0]              k_purchase_val,
    output logic [N_PORTS-1:0]              k_purchase_rdy,
    input  logic [N_PORTS*COIN_WIDTH-1:0]   k_coin_msg,
    input  logic [N_PORTS-1:0]              k_coin_val,
    output logic [N_PORTS-1:0]              k_coin_rdy,
    output logic [N_PORTS-1:0]              k_dispense_val,
    input  logic [N_PORTS-1:0]              k_dispense_rdy,
    output logic [COIN_WIDTH-1:0]           k_change_msg,
    output logic [N_PORTS-1:0]              k_change_val,
    input  logic [N_PORTS-1:0]              k_change_rdy,
    output logic [WIDTH-1:0]                c_purchase_msg,
    output logic                            c_purchase_val,
    input  logic                            c_purchase_rdy,
    output logic [COIN_WIDTH-1:0]           c_coin_msg,
    output logic                            c_coin_val,
    input  logic                            c_coin_rdy,
    input  logic                            c_dispense_msg,
    input  logic                            c_dispense_val,
    output logic                            c_dispense_rdy,
    input  logic [COIN_WIDTH-1:0]           c_change_msg,
    input  logic                            c_change_val,
    output logic                            c_change_rdy,
    output logic [N_PORTS-1:0]              grant,
    output logic                            session_abort
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    session_state_t       state_q, state_d;
    logic [N_PORTS-1:0]   grant_q, arb_gnt;
    logic [PORT_W-1:0]    gidx_q, arb_idx, rr_ptr;
    logic                 arb_any;
    logic [PRICE_W-1:0]   price_n, new_price;
    logic [NICKEL_W-1:0]  dep_n, due_n, ret_n, dep_sum, ret_sum;
    logic [IDLE_W-1:0]    idle_cnt;
    logic                 abort_q, xfer, timed_out;
    logic                 sel_pval, sel_cval, sel_drdy, sel_xrdy;
    logic [COIN_WIDTH-1:0] sel_cmsg;
    logic                 unused_dispense_msg;

    // The dispense payload carries nothing the kiosks need.
    assign unused_dispense_msg = c_dispense_msg;

    rr_arbiter #(.N_PORTS(N_PORTS), .PORT_W(PORT_W)) u_rr (
        .req (k_purchase_val),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // Select the granted kiosk's inputs, and the price of the kiosk being granted.
    always_comb begin
        sel_pval  = 1'b0;
        sel_cval  = 1'b0;
        sel_cmsg  = '0;
        sel_drdy  = 1'b0;
        sel_xrdy  = 1'b0;
        new_price = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant_q[i]) begin
                sel_pval = k_purchase_val[i];
                sel_cval = k_coin_val[i];
                sel_cmsg = k_coin_msg[i*COIN_WIDTH +: COIN_WIDTH];
                sel_drdy = k_dispense_rdy[i];
                sel_xrdy = k_change_rdy[i];
            end
            if (arb_gnt[i]) new_price = k_purchase_msg[i*PRICE_W +: PRICE_W];
        end
    end

    assign dep_sum        = nickel_add(dep_n, coin_nickels(sel_cmsg));
    assign ret_sum        = nickel_add(ret_n, coin_nickels(c_change_msg));
    assign c_purchase_msg = price_to_fixed(price_n);
    assign grant          = grant_q;
    assign session_abort  = abort_q;

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and channel routing; only the granted kiosk is ever connected.
    always_comb begin
        state_d        = state_q;
        k_purchase_rdy = '0;
        k_coin_rdy     = '0;
        k_dispense_val = '0;
        k_change_val   = '0;
        k_change_msg   = '0;
        c_purchase_val = 1'b0;
        c_coin_val     = 1'b0;
        c_coin_msg     = '0;
        c_dispense_rdy = 1'b0;
        c_change_rdy   = 1'b0;
        xfer           = 1'b0;
        timed_out      = 1'b0;
        unique case (state_q)
            IDLE: if (arb_any) state_d = PURCHASE;
            PURCHASE: begin
                c_purchase_val = sel_pval;
                k_purchase_rdy = grant_q & {N_PORTS{c_purchase_rdy}};
                xfer           = sel_pval && c_purchase_rdy;
                if (xfer) state_d = COIN;
            end
            COIN: begin
                c_coin_val = sel_cval;
                c_coin_msg = sel_cmsg;
                k_coin_rdy = grant_q & {N_PORTS{c_coin_rdy}};
                xfer       = sel_cval && c_coin_rdy;
                if (c_dispense_val) state_d = DISPENSE;
            end
            DISPENSE: begin
                k_dispense_val = grant_q & {N_PORTS{c_dispense_val}};
                c_dispense_rdy = sel_drdy;
                xfer           = c_dispense_val && sel_drdy;
                if (xfer) state_d = (dep_n > NICKEL_W'(price_n)) ? CHANGE : RELEASE;
            end
            CHANGE: begin
                k_change_val = grant_q & {N_PORTS{c_change_val}};
                k_change_msg = c_change_msg;
                c_change_rdy = sel_xrdy;
                xfer         = c_change_val && sel_xrdy;
                if (xfer && (ret_sum >= due_n)) state_d = RELEASE;
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if ((state_q != IDLE) && (state_q != RELEASE) && !xfer &&
            (idle_cnt == IDLE_W'(TIMEOUT - 1))) begin
            timed_out = 1'b1;
            state_d   = RELEASE;
        end
    end

    // Session datapath: grant, price, money counters, idle timer, rr pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr   <= '0;
            price_n  <= '0;
            dep_n    <= '0;
            due_n    <= '0;
            ret_n    <= '0;
            idle_cnt <= '0;
            abort_q  <= 1'b0;
        end else begin
            abort_q <= timed_out;
            unique case (state_q)
                IDLE: if (arb_any) begin
                    grant_q <= arb_gnt;
                    gidx_q  <= arb_idx;
                    price_n <= new_price;
                end
                COIN:     if (xfer) dep_n <= dep_sum;
                DISPENSE: if (xfer) due_n <= (dep_n > NICKEL_W'(price_n)) ?
                                             dep_n - NICKEL_W'(price_n) : '0;
                CHANGE:   if (xfer) ret_n <= ret_sum;
                RELEASE: begin
                    grant_q <= '0;
                    gidx_q  <= '0;
                    rr_ptr  <= (gidx_q == PORT_W'(N_PORTS - 1)) ? '0 : gidx_q + PORT_W'(1);
                    price_n <= '0;
                    dep_n   <= '0;
                    due_n   <= '0;
                    ret_n   <= '0;
                end
                default: ;
            endcase
            if ((state_q == IDLE) || (state_q == RELEASE) || xfer || timed_out)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

endmodule
